// File: rtl/sd_bank_writer.sv
// ---------------------------------------------------------------------------
// sd_bank_writer
//   Takes the generator's packed state word, word address and bank-toggle
//   level, and commits each finished word into ping-pong on-chip RAM. When the
//   generator flips banks, a full bank is flagged to the host for SD-card copy.
//   A second flip that arrives before the host acknowledges sets a sticky
//   overrun flag.
//
// Ports
//   clk, rst     : clock and synchronous active-high reset
//   sd_data_in   : packed state word from the generator
//   adr_in       : generator word address; a change means the old word is done
//   cpy_en_in    : bank-toggle level; each flip marks a full bank
//   mem_we       : RAM write strobe, one cycle per word
//   mem_addr     : RAM word address
//   mem_wdata    : RAM write data
//   bank_ready   : a full bank is waiting for the host
//   bank_id      : index of the bank that is waiting
//   bank_ack     : host pulse, copy of bank_id finished
//   overrun      : sticky, a bank completed while the previous one was pending
//   words_out    : running count of committed words
//
// Build option
//   LOG_WORD_COUNT_EN : when defined, words_out counts mem_we cycles and wraps
//                       at 2^32. When undefined, words_out is tied to zero.
// ---------------------------------------------------------------------------
module sd_bank_writer #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 32,
    parameter int BANK_SPLIT = 16383
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sd_data_in,
    input  logic [ADDR_W-1:0] adr_in,
    input  logic              cpy_en_in,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              bank_ready,
    output logic              bank_id,
    input  logic              bank_ack,
    output logic              overrun,
    output logic [31:0]       words_out
);

    localparam logic [ADDR_W-1:0] SPLIT = ADDR_W'(BANK_SPLIT);

    typedef enum logic {B_IDLE, B_READY} bank_st_e;

    logic [DATA_W-1:0] sd_q;
    logic [ADDR_W-1:0] adr_q;
    logic              cpy_q;

    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    bank_st_e          state_q, state_d;
    logic              bank_id_q, bank_id_d;
    logic              overrun_q, overrun_d;

    logic              adr_chg;
    logic              toggle;
    logic              filled_bank;

    assign adr_chg     = (adr_in != adr_q);
    assign toggle      = (cpy_en_in != cpy_q);
    // Bank that just completed is judged by the last captured address.
    assign filled_bank = (adr_q > SPLIT);

    // Input capture runs through reset too, so releasing reset never shows a
    // stale address or toggle edge.
    always_ff @(posedge clk) begin
        sd_q  <= sd_data_in;
        adr_q <= adr_in;
        cpy_q <= cpy_en_in;
    end

    // Word commit: an address change means the word at adr_q is complete.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q <= adr_chg;
            if (adr_chg) begin
                mem_addr_q  <= adr_q;
                mem_wdata_q <= sd_q;
            end
        end
    end

    // Bank FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= B_IDLE;
            bank_id_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bank_id_q <= bank_id_d;
            overrun_q <= overrun_d;
        end
    end

    // Bank FSM next state. A toggle in the same cycle as an ack takes
    // priority: the new bank is reported and no overrun is recorded, since
    // the host did finish the previous bank.
    always_comb begin
        state_d   = state_q;
        bank_id_d = bank_id_q;
        overrun_d = overrun_q;
        unique case (state_q)
            B_IDLE: begin
                if (toggle) begin
                    state_d   = B_READY;
                    bank_id_d = filled_bank;
                end
            end
            B_READY: begin
                if (toggle) begin
                    bank_id_d = filled_bank;
                    if (!bank_ack) overrun_d = 1'b1;
                end else if (bank_ack) begin
                    state_d = B_IDLE;
                end
            end
            default: state_d = B_IDLE;
        endcase
    end

`ifdef LOG_WORD_COUNT_EN
    logic [31:0] words_q, words_d;

    assign words_d = words_q + 32'd1;

    always_ff @(posedge clk) begin
        if (rst)           words_q <= '0;
        else if (mem_we_q) words_q <= words_d;
    end

    assign words_out = words_q;
`else
    assign words_out = 32'd0;
`endif

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign bank_ready = (state_q == B_READY);
    assign bank_id    = bank_id_q;
    assign overrun    = overrun_q;

endmodule
